// File: rtl/baud_gen_pkg.sv
// Shared constants and helpers for the baud tick generator family.
// Holds OSR legality limits, default widths and an elaboration-time clog2.
package baud_gen_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OSR_MIN    = 4;
    localparam int OSR_MAX    = 64;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds frac_i on add_i, clears on clr_i, exposes carry.
// Carry is combinational from the current accumulator; state updates one cycle later.
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              add_i,
    input  logic              clr_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
    assign carry_o = sum[FRAC_W];

    always_comb begin
        acc_d = acc_q;
        if (clr_i)      acc_d = '0;
        else if (add_i) acc_d = sum[FRAC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: oversample, mid-bit and end-of-bit ticks, registered one cycle after terminal count.
// No backpressure; enable holds state. Fractional divisor exists only when BAUD_GEN_FRAC_EN is defined.
module baud_tick_gen
    import baud_gen_pkg::*;
#(
    parameter int  CNT_W  = CNT_W_DEF,
    parameter int  FRAC_W = FRAC_W_DEF,
    parameter int  OSR    = 16,
    localparam int PH_W   = clog2(OSR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  baud_int,
    input  logic [FRAC_W-1:0] baud_frac,
    input  logic              load,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic [PH_W-1:0]   os_phase,
    output logic              cfg_ack
);

    if (OSR < OSR_MIN || OSR > OSR_MAX || (OSR % 2) != 0) begin : g_osr_check
        $error("baud_tick_gen: OSR must be even and within %0d..%0d", OSR_MIN, OSR_MAX);
    end

`ifdef BAUD_GEN_FRAC_EN
    localparam int CW = CNT_W + 1;
`else
    localparam int CW = CNT_W;
`endif

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] act_int_q, act_int_d, sh_int_q, sh_int_d;
    logic             pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             tc, apply, carry;
    logic [CNT_W-1:0] use_int;

    // A load arriving with the apply point bypasses the shadow so the newest value wins.
    assign tc      = enable && (cnt_q == '0);
    assign apply   = (tc && (load || pend_q)) || (pend_q && !enable);
    assign use_int = apply ? (load ? baud_int : sh_int_q) : act_int_q;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] act_frac_q, sh_frac_q;
    logic              acc_add;

    assign acc_add = tc && !resync && !apply;

    baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .add_i   (acc_add),
        .clr_i   (apply),
        .frac_i  (act_frac_q),
        .carry_o (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            act_frac_q <= '0;
            sh_frac_q  <= '0;
        end else begin
            if (load)  sh_frac_q  <= baud_frac;
            if (apply) act_frac_q <= load ? baud_frac : sh_frac_q;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^baud_frac;
    assign carry       = 1'b0;
`endif

    always_comb begin
        sh_int_d  = load ? baud_int : sh_int_q;
        act_int_d = use_int;
        pend_d    = apply ? 1'b0 : (load | pend_q);
        cfg_ack_d = apply;
        os_tick_d = tc && !resync;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        if (resync) begin
            cnt_d   = CW'(use_int);
            phase_d = '0;
        end else begin
            if (tc)          cnt_d = CW'(use_int) + CW'(carry && !apply);
            else if (enable) cnt_d = cnt_q - CW'(1);
            // An emitted tick always advances phase, even if enable drops right after it.
            if (os_tick_q) phase_d = (phase_q == PH_W'(OSR-1)) ? '0 : phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            act_int_q <= '0;
            sh_int_q  <= '0;
            pend_q    <= 1'b0;
            os_tick_q <= 1'b0;
            cfg_ack_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            act_int_q <= act_int_d;
            sh_int_q  <= sh_int_d;
            pend_q    <= pend_d;
            os_tick_q <= os_tick_d;
            cfg_ack_q <= cfg_ack_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign os_phase = phase_q;
    assign cfg_ack  = cfg_ack_q;
    assign bit_tick = os_tick_q && (phase_q == PH_W'(OSR-1));
    assign mid_tick = os_tick_q && (phase_q == PH_W'(OSR/2-1));

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: period table plus load/resync/hold/boundary/reset sequences.
module tb_baud_tick_gen;

    localparam int CNT_W  = 10;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
    localparam int PH_W   = 4;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, enable, load, resync;
    logic [CNT_W-1:0]  baud_int;
    logic [FRAC_W-1:0] baud_frac;
    logic              os_tick, bit_tick, mid_tick, cfg_ack;
    logic [PH_W-1:0]   os_phase;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int bint;
        int bfrac;
        int p0, p1, p2, p3;
        int total;
    } vec_t;

    vec_t vecs[5];

    baud_tick_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .baud_int  (baud_int),
        .baud_frac (baud_frac),
        .load      (load),
        .resync    (resync),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .mid_tick  (mid_tick),
        .os_phase  (os_phase),
        .cfg_ack   (cfg_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_os(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < budget);
        if (!os_tick) n = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0; resync = 1'b0;
        baud_int = '0; baud_frac = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic cfg(input int bi, input int bf);
        enable    = 1'b0;
        baud_int  = bi[CNT_W-1:0];
        baud_frac = bf[FRAC_W-1:0];
        load = 1'b1; step(); load = 1'b0;
        step();
        chk("cfg_ack_pulse", int'(cfg_ack), 1);
        step();
        chk("cfg_ack_clear", int'(cfg_ack), 0);
    endtask

    function automatic int tick_code(input int k);
        int p;
        p = k % OSR;
        return p + ((p == OSR/2-1) ? 16 : 0) + ((p == OSR-1) ? 32 : 0);
    endfunction

    function automatic int dut_code();
        return int'(os_phase) + (mid_tick ? 16 : 0) + (bit_tick ? 32 : 0);
    endfunction

    function automatic int all_out();
        return dut_code() + (os_tick ? 64 : 0) + (cfg_ack ? 128 : 0);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, total, cnt, ticks, acks;

`ifdef BAUD_GEN_FRAC_EN
        vecs[0] = '{3, 0,  4, 4, 4, 4, 64};
        vecs[1] = '{4, 4,  5, 5, 5, 6, 84};
        vecs[2] = '{2, 8,  3, 4, 3, 4, 56};
        vecs[3] = '{0, 15, 1, 2, 2, 2, 31};
        vecs[4] = '{5, 1,  6, 6, 6, 6, 97};
`else
        vecs[0] = '{3, 0,  4, 4, 4, 4, 64};
        vecs[1] = '{4, 4,  5, 5, 5, 5, 80};
        vecs[2] = '{2, 8,  3, 3, 3, 3, 48};
        vecs[3] = '{0, 15, 1, 1, 1, 1, 16};
        vecs[4] = '{5, 1,  6, 6, 6, 6, 96};
`endif

        do_reset();
        chk("reset_outputs", all_out(), 0);

        // Period table: each row reconfigures from reset and runs 16 periods.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            cfg(vecs[r].bint, vecs[r].bfrac);
            enable = 1'b1;
            total  = 0;
            wait_os(10, n);
            chk($sformatf("row%0d_first_tick", r), n, 1);
            chk($sformatf("row%0d_flags0", r), dut_code(), tick_code(0));
            for (int k = 1; k <= 16; k++) begin
                wait_os(20, n);
                total += n;
                if (k == 1) chk($sformatf("row%0d_period1", r), n, vecs[r].p0);
                if (k == 2) chk($sformatf("row%0d_period2", r), n, vecs[r].p1);
                if (k == 3) chk($sformatf("row%0d_period3", r), n, vecs[r].p2);
                if (k == 4) chk($sformatf("row%0d_period4", r), n, vecs[r].p3);
                chk($sformatf("row%0d_flags%0d", r, k), dut_code(), tick_code(k));
            end
            chk($sformatf("row%0d_total16", r), total, vecs[r].total);
        end

        // Load coincident with terminal count: bypass, ack next cycle, accumulator cleared.
        do_reset();
        cfg(3, 8);
        enable = 1'b1;
        wait_os(10, n);
        chk("ldtc_first", n, 1);
        step(); step(); step();
        chk("ldtc_pre_tick", int'(os_tick), 0);
        baud_int = 10'd7; baud_frac = 4'd8; load = 1'b1;
        step();
        load = 1'b0;
        chk("ldtc_tick", int'(os_tick), 1);
        chk("ldtc_ack", int'(cfg_ack), 1);
        wait_os(20, n);
        chk("ldtc_period1", n, 8);
        chk("ldtc_ack_once", int'(cfg_ack), 0);
        wait_os(20, n);
        chk("ldtc_period2", n, 8);
        wait_os(20, n);
        chk("ldtc_period3", n, FRAC_EN ? 9 : 8);

        // Resync at phase 9 coincident with terminal count.
        do_reset();
        cfg(3, 0);
        enable = 1'b1;
        for (int k = 0; k <= 8; k++) wait_os(10, n);
        chk("rs_phase8", int'(os_phase), 8);
        step(); step(); step();
        chk("rs_phase9", int'(os_phase), 9);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("rs_suppressed", int'(os_tick), 0);
        chk("rs_phase0", int'(os_phase), 0);
        wait_os(10, n);
        chk("rs_period", n, 4);
        chk("rs_flags", dut_code(), tick_code(0));
        cnt = 1;
        while (!bit_tick && cnt < 40) begin
            wait_os(10, n);
            cnt++;
        end
        chk("rs_bit_after", cnt, 16);

        // Enable dropped mid-count: everything freezes, then resumes from the held count.
        do_reset();
        cfg(9, 8);
        enable = 1'b1;
        wait_os(10, n);
        step(); step(); step();
        enable = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (os_tick) ticks++;
        end
        chk("hold_no_ticks", ticks, 0);
        chk("hold_phase", int'(os_phase), 1);
        enable = 1'b1;
        wait_os(20, n);
        chk("hold_resume", n, 7);
        chk("hold_tick_phase", int'(os_phase), 1);
        wait_os(20, n);
        chk("hold_acc_kept", n, FRAC_EN ? 11 : 10);

        // Largest integer divisor with a fraction carry.
        do_reset();
        cfg(1023, 8);
        enable = 1'b1;
        wait_os(10, n);
        chk("max_first", n, 1);
        wait_os(1100, n);
        chk("max_period1", n, 1024);
        wait_os(1100, n);
        chk("max_period2", n, FRAC_EN ? 1025 : 1024);

        // Reset while a load is pending: no ack, divisor back to zero.
        do_reset();
        cfg(50, 0);
        enable = 1'b1;
        wait_os(10, n);
        baud_int = 10'd3; load = 1'b1;
        step();
        load = 1'b0;
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        chk("rstpend_outputs", all_out(), 0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cfg_ack) acks++;
        end
        chk("rstpend_no_ack", acks, 0);
        chk("rstpend_idle_outputs", all_out(), 0);
        enable = 1'b1;
        wait_os(10, n);
        chk("rstpend_first", n, 1);
        wait_os(10, n);
        chk("rstpend_period", n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
